// File: rtl/ycr_dmem_router.sv
// rtl/ycr_dmem_router.sv - single-outstanding dmem router: core LSU to timer or default memory port
// Optional response timeout with drain state: YCR_DMEM_ROUTER_TIMEOUT_EN

`ifndef YCR_DMEM_AWIDTH
`define YCR_DMEM_AWIDTH 32
`endif
`ifndef YCR_DMEM_DWIDTH
`define YCR_DMEM_DWIDTH 32
`endif

module ycr_dmem_router #(
    parameter logic [`YCR_DMEM_AWIDTH-1:0] TMR_ADDR_MASK    = 32'hFFFF_FFE0,
    parameter logic [`YCR_DMEM_AWIDTH-1:0] TMR_ADDR_PATTERN = 32'h0049_0000
`ifdef YCR_DMEM_ROUTER_TIMEOUT_EN
    ,
    parameter int unsigned                 TIMEOUT_CYCLES   = 16
`endif
) (
    input  logic                        clk,
    input  logic                        rst_n,

    input  logic                        core_req,
    input  logic                        core_cmd,
    input  logic [1:0]                  core_width,
    input  logic [`YCR_DMEM_AWIDTH-1:0] core_addr,
    input  logic [`YCR_DMEM_DWIDTH-1:0] core_wdata,
    output logic                        core_req_ack,
    output logic [`YCR_DMEM_DWIDTH-1:0] core_rdata,
    output logic [1:0]                  core_resp,

    output logic                        port_cmd,
    output logic [1:0]                  port_width,
    output logic [`YCR_DMEM_AWIDTH-1:0] port_addr,
    output logic [`YCR_DMEM_DWIDTH-1:0] port_wdata,

    output logic                        tmr_req,
    input  logic                        tmr_req_ack,
    input  logic [`YCR_DMEM_DWIDTH-1:0] tmr_rdata,
    input  logic [1:0]                  tmr_resp,

    output logic                        mem_req,
    input  logic                        mem_req_ack,
    input  logic [`YCR_DMEM_DWIDTH-1:0] mem_rdata,
    input  logic [1:0]                  mem_resp
);

    localparam logic [1:0] RESP_NOTRDY = 2'b00;
    localparam logic [1:0] RESP_RDY_ER = 2'b10;

`ifdef YCR_DMEM_ROUTER_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_DRAIN = 2'd2} state_t;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;
`endif

    state_t                      state_q, state_d;
    logic                        sel_tmr_q, sel_tmr_d;
    logic                        hit;
    logic [1:0]                  sel_resp;
    logic [`YCR_DMEM_DWIDTH-1:0] sel_rdata;

    assign port_cmd   = core_cmd;
    assign port_width = core_width;
    assign port_addr  = core_addr;
    assign port_wdata = core_wdata;

    assign hit       = ((core_addr & TMR_ADDR_MASK) == TMR_ADDR_PATTERN);
    // Only the port latched at accept is ever observed; the other port's responses are dropped.
    assign sel_resp  = sel_tmr_q ? tmr_resp  : mem_resp;
    assign sel_rdata = sel_tmr_q ? tmr_rdata : mem_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            sel_tmr_q <= 1'b0;
`ifdef YCR_DMEM_ROUTER_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            sel_tmr_q <= sel_tmr_d;
`ifdef YCR_DMEM_ROUTER_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        sel_tmr_d    = sel_tmr_q;
        tmr_req      = 1'b0;
        mem_req      = 1'b0;
        core_req_ack = 1'b0;
        core_resp    = RESP_NOTRDY;
        core_rdata   = '0;
`ifdef YCR_DMEM_ROUTER_TIMEOUT_EN
        cnt_d        = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                tmr_req      = core_req & hit;
                mem_req      = core_req & ~hit;
                // Slave ack with no request behind it must not reach the core.
                core_req_ack = core_req & (hit ? tmr_req_ack : mem_req_ack);
                if (core_req_ack) begin
                    sel_tmr_d = hit;
                    state_d   = ST_WAIT;
`ifdef YCR_DMEM_ROUTER_TIMEOUT_EN
                    cnt_d     = '0;
`endif
                end
            end
            ST_WAIT: begin
                if (sel_resp != RESP_NOTRDY) begin
                    core_resp  = sel_resp;
                    core_rdata = sel_rdata;
                    state_d    = ST_IDLE;
                end
`ifdef YCR_DMEM_ROUTER_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    core_resp = RESP_RDY_ER;
                    state_d   = ST_DRAIN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
`ifdef YCR_DMEM_ROUTER_TIMEOUT_EN
            ST_DRAIN: begin
                if (sel_resp != RESP_NOTRDY) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

endmodule
